// File: rtl/uart_receiver.sv
// UART receiver with 16x oversampling and a configurable number of data and stop bits.
// rx passes through a 2-flop synchronizer first. dout, rx_done_tick and framing_err
// are registered, so in the rx_done_tick cycle dout already holds the new byte.
module uart_receiver #(
  parameter int DBIT    = 8,   // data bits per frame, 6..8
  parameter int SB_TICK = 16   // s_ticks in the stop period: 16/24/32 = 1/1.5/2 stop bits
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       framing_err
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [4:0] MID_START = 5'd7;
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);

  state_t     state, state_next;
  logic       rx_meta, rx_s;
  logic [4:0] s_cnt, s_cnt_next;
  logic [2:0] n_cnt, n_cnt_next;
  logic [7:0] b_reg, b_next;
  logic [7:0] dout_next;
  logic       done_next, ferr_next;

  // Synchronize the asynchronous serial line. Both flops preset to idle-high so
  // that a reset never manufactures a false start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      framing_err  <= 1'b0;
    end else begin
      state        <= state_next;
      s_cnt        <= s_cnt_next;
      n_cnt        <= n_cnt_next;
      b_reg        <= b_next;
      dout         <= dout_next;
      rx_done_tick <= done_next;
      framing_err  <= ferr_next;
    end
  end

  // Next-state logic. Outside IDLE, nothing moves unless s_tick is high.
  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    b_next     = b_reg;
    dout_next  = dout;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      IDLE: begin
        // Start detection ignores s_tick, so the half-bit count starts cleanly.
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == MID_START) begin
            // Mid start bit: a line that is high again was only a glitch.
            s_cnt_next = '0;
            n_cnt_next = '0;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            // LSB arrives first, so shift right and insert at the top of the
            // DBIT-wide field. Bits above DBIT-1 stay zero.
            s_cnt_next         = '0;
            b_next             = b_reg >> 1;
            b_next[DBIT-1]     = rx_s;
            n_cnt_next         = n_cnt + 3'd1;
            if (n_cnt == LAST_BIT) begin
              state_next = STOP;
            end
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            // The byte is delivered even when the stop bit is bad.
            state_next = IDLE;
            s_cnt_next = '0;
            dout_next  = b_reg;
            done_next  = 1'b1;
            ferr_next  = ~rx_s;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver. Frames are driven at 64 clk per
// bit, and s_tick is high one clk in every 4. Captured pulses are compared with
// expected (byte, framing) pairs that are derived from the frames sent.
module tb_uart_receiver;

  logic       clk, reset, s_tick;
  logic       rx, rx7;
  logic [7:0] dout, dout7;
  logic       rx_done_tick, framing_err, rx_done_tick7, framing_err7;

  int total = 0;
  int bad   = 0;

  uart_receiver u_dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done_tick(rx_done_tick), .framing_err(framing_err)
  );

  uart_receiver #(.DBIT(7), .SB_TICK(32)) u_dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7),
    .dout(dout7), .rx_done_tick(rx_done_tick7), .framing_err(framing_err7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The s_tick divider and the edge counter. The tick is sampled at the edge where
  // the DUT sees it.
  int edge_no = 0;
  int tick_edges[$];
  initial begin
    int div;
    div = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      edge_no++;
      if (s_tick) tick_edges.push_back(edge_no);
      #1;
      s_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Pulse capture, sampled on the falling edge.
  logic [7:0] got_d[$];
  logic       got_f[$];
  logic [7:0] got7_d[$];
  logic       got7_f[$];
  int pulse7_edge = -1;
  int orphan_err  = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rx_done_tick) begin
        got_d.push_back(dout);
        got_f.push_back(framing_err);
      end
      if (rx_done_tick7) begin
        got7_d.push_back(dout7);
        got7_f.push_back(framing_err7);
        pulse7_edge = edge_no;
      end
      if ((framing_err && !rx_done_tick) || (framing_err7 && !rx_done_tick7)) orphan_err++;
    end
  end

  logic [7:0] exp_d[$];
  logic       exp_f[$];
  int fall_edge = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each wait ends 1 time unit after a rising edge, so stimulus stays aligned.
  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx7 = v;
    else     rx  = v;
  endtask

  // Drive one frame: start bit, nbits data bits LSB first, then the stop level held
  // for stop_clk clocks. The line is then left high. For the 8-bit receiver, the
  // frame's expected result is queued.
  task automatic send(input bit sel, input logic [7:0] data, input int nbits,
                      input logic stop_val, input int stop_clk);
    logic [7:0] mask;
    mask = 8'((1 << nbits) - 1);
    set_line(sel, 1'b0);
    if (sel) fall_edge = edge_no;
    clk_n(64);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, data[i]);
      clk_n(64);
    end
    set_line(sel, stop_val);
    clk_n(stop_clk);
    set_line(sel, 1'b1);
    if (!sel) begin
      exp_d.push_back(data & mask);
      exp_f.push_back(~stop_val);
    end
  endtask

  // Compare the captured pulses with the expected ones, then clear both queues.
  task automatic check_q(input string tag);
    int n;
    chk({tag, "_npulse"}, 32'(got_d.size()), 32'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_dout"}, 32'(got_d[i]), 32'(exp_d[i]));
      chk({tag, "_ferr"}, 32'(got_f[i]), 32'(exp_f[i]));
    end
    got_d.delete(); got_f.delete(); exp_d.delete(); exp_f.delete();
  endtask

  initial begin
    logic [7:0] last_dout;
    logic [7:0] rnd;
    logic       serr;
    int         cnt, exp_edge;

    rx = 1'b1; rx7 = 1'b1; reset = 1'b1;
    clk_n(3);
    chk("rst_dout",  32'(dout), 32'h0);
    chk("rst_done",  32'(rx_done_tick), 32'h0);
    chk("rst_ferr",  32'(framing_err), 32'h0);
    chk("rst_dout7", 32'(dout7), 32'h0);
    reset = 1'b0;
    clk_n(8);

    // Single 0x55 frame with a good stop bit.
    send(1'b0, 8'h55, 8, 1'b1, 64);
    clk_n(64);
    check_q("f55");
    chk("hold55", 32'(dout), 32'h55);

    // Back-to-back frames with no idle gap between stop and start.
    send(1'b0, 8'hA5, 8, 1'b1, 64);
    send(1'b0, 8'h3C, 8, 1'b1, 64);
    clk_n(64);
    check_q("b2b");
    last_dout = 8'h3C;

    // A 16-clk low glitch is rejected at mid start bit.
    rx = 1'b0; clk_n(16); rx = 1'b1;
    clk_n(200);
    check_q("glitch");
    chk("glitch_hold", 32'(dout), 32'(last_dout));

    // A low stop bit still delivers the byte, with framing_err set.
    send(1'b0, 8'hF0, 8, 1'b0, 48);
    clk_n(128);
    check_q("ferr");
    chk("ferr_hold", 32'(dout), 32'hF0);

    // A reset after 4 data bits of 0xFF aborts the frame and clears dout.
    rx = 1'b0; clk_n(64);
    rx = 1'b1; clk_n(4 * 64);
    reset = 1'b1; clk_n(1); reset = 1'b0;
    chk("abort_dout", 32'(dout), 32'h0);
    clk_n(5 * 64);
    check_q("abort");
    send(1'b0, 8'h81, 8, 1'b1, 64);
    clk_n(64);
    check_q("post_abort");

    // Break: a line held low gives back-to-back frames of zero with framing errors.
    // Two complete frames fit in the low time. The line returns high before the
    // third frame's mid start bit.
    rx = 1'b0; clk_n(1232); rx = 1'b1;
    clk_n(200);
    exp_d.push_back(8'h00); exp_f.push_back(1'b1);
    exp_d.push_back(8'h00); exp_f.push_back(1'b1);
    check_q("break");

    // Random frames, gaps and framing errors. A bad stop bit is followed by at
    // least one bit time of idle.
    last_dout = 8'h00;
    for (int k = 0; k < 14; k++) begin
      rnd  = 8'($urandom);
      serr = ($urandom_range(0, 3) == 0);
      send(1'b0, rnd, 8, ~serr, serr ? 48 : 64);
      last_dout = rnd;
      clk_n(serr ? 64 + $urandom_range(0, 80) : $urandom_range(0, 80));
    end
    clk_n(128);
    check_q("rand");
    chk("rand_hold", 32'(dout), 32'(last_dout));

    // DBIT=7, SB_TICK=32 receiver: value and latency. START is entered at
    // fall_edge+3, so the first counted tick is at or after fall_edge+4. The pulse
    // is visible right after the 8+16*7+32 = 152nd such tick, which is
    // 7+112+32 ticks after the first.
    tick_edges.delete();
    send(1'b1, 8'h5A, 7, 1'b1, 128);
    clk_n(64);
    chk("d7_npulse", 32'(got7_d.size()), 32'd1);
    if (got7_d.size() > 0) begin
      chk("d7_dout", 32'(got7_d[0]), 32'h5A);
      chk("d7_ferr", 32'(got7_f[0]), 32'h0);
    end
    cnt = 0; exp_edge = -2;
    foreach (tick_edges[i]) begin
      if (tick_edges[i] >= fall_edge + 4) begin
        cnt++;
        if (cnt == 152) exp_edge = tick_edges[i];
      end
    end
    chk("d7_latency", 32'(pulse7_edge), 32'(exp_edge));
    chk("d7_hold", 32'(dout7), 32'h5A);
    chk("orphan_ferr", 32'(orphan_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame; legal values 6..8.
REQ-002 SHALL have parameter SB_TICK, default 16, s_tick count for the stop period (16/24/32 = 1/1.5/2 stop bits).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_tick  input  1  16x-oversampling enable from baud_gen, one clk wide.
REQ-006 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port dout  output  8  last received byte, LSB-aligned, bits above DBIT-1 zero.
REQ-008 SHALL have port rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-009 SHALL have port framing_err  output  1  one-clk pulse, coincident with rx_done_tick, when sampled stop bit is 0.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer preset to 1; all FSM decisions use the synchronized value rx_s.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP with registered state, 5-bit tick counter s_cnt, 3-bit bit counter n_cnt, 8-bit shift register b_reg.
REQ-012 IDLE: when rx_s=0, go to START and clear s_cnt, regardless of s_tick in that cycle.
REQ-013 START: on each s_tick increment s_cnt; on the s_tick where s_cnt=7 (mid start bit) go to DATA with s_cnt=0, n_cnt=0 if rx_s=0, else return to IDLE (glitch rejection, no pulse).
REQ-014 DATA: on each s_tick increment s_cnt; on the s_tick where s_cnt=15, shift rx_s in at bit DBIT-1 of the DBIT-wide field (LSB first on line), clear s_cnt, increment n_cnt.
REQ-015 DATA: after the sample with n_cnt=DBIT-1, go to STOP with s_cnt=0.
REQ-016 STOP: on each s_tick increment s_cnt; on the s_tick where s_cnt=SB_TICK-1, go to IDLE, load dout from b_reg, assert rx_done_tick for that one cycle.
REQ-017 STOP: framing_err SHALL assert with rx_done_tick iff rx_s=0 on that final s_tick; dout SHALL still be loaded.
REQ-018 dout SHALL hold its value between frames and change only on the rx_done_tick cycle.
REQ-019 Counters SHALL advance only on cycles with s_tick=1; no state change in START/DATA/STOP without s_tick.
REQ-020 If rx_s remains 0 after STOP (break), the next cycle SHALL enter START; a break yields repeated frames with dout=0, framing_err=1.
REQ-021 Frame latency: rx_done_tick SHALL occur 7+16*DBIT+SB_TICK s_ticks after the first s_tick following rx_s falling, plus 2 clk synchronizer delay from rx.

Reset
REQ-022 On reset=1 at a clk edge: state=IDLE, s_cnt=0, n_cnt=0, b_reg=0, dout=0, rx_done_tick=0, framing_err=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL abort the frame without a rx_done_tick pulse; dout SHALL read 0.
REQ-024 If rx=0 while reset deasserts, START SHALL be entered only after the synchronizer delivers rx_s=0 (2 clk).

Verification (s_tick one clk every 4 clk; bit time 64 clk)
REQ-025 Send 0x55, 1 stop bit -> one rx_done_tick, dout=0x55, framing_err=0.
REQ-026 Back-to-back frames 0xA5 then 0x3C, no idle gap -> two pulses, dout 0xA5 then 0x3C.
REQ-027 rx low pulse of 16 clk (< half bit) in IDLE -> FSM returns to IDLE, no rx_done_tick, dout unchanged.
REQ-028 Frame 0xF0 with stop bit driven 0 -> rx_done_tick=1 and framing_err=1 same cycle, dout=0xF0.
REQ-029 Assert reset for 1 clk after 4 data bits of 0xFF, then send 0x81 -> no pulse for aborted frame, next pulse dout=0x81.
REQ-030 DBIT=7, SB_TICK=32, send 0x5A (7 bits) -> dout=0x5A, pulse exactly 7+112+32 s_ticks after start detection.
